arm_imm_rot_encoder: RTL and testbench

//  Inverse of the operand-2 rotate-immediate decoder. Takes a 32-bit constant and searches
//  for the ARM encoding {rot4, imm8} such that value == ROR({24'b0,imm8}, 2*rot4).
//  If TRY_INVERT=1 and no encoding exists, the block also searches ~value (MOV->MVN, AND->BIC).

---
 rtl/arm_imm_rot_encoder.sv | 127 ++++++++++++
 tb/tb_arm_imm_rot_encoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/arm_imm_rot_encoder.sv
// Finds the ARM rotate-immediate operand {rot4, imm8} for a 32-bit constant, testing one
// rotation per cycle, with an optional second pass on the bitwise inverse of the constant.
module arm_imm_rot_encoder #(
    parameter bit TRY_INVERT = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] operand12,
    output logic        ok,
    output logic        inverted,
    output logic        carry_out,
    output logic        carry_valid,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEARCH     = 2'd1,
        SEARCH_INV = 2'd2,
        DONE       = 2'd3
    } state_t;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready is high only in IDLE; out_valid is high only in DONE and holds until out_ready.
    state_t      state, state_n;
    logic [31:0] cand, cand_n;
    logic [3:0]  r, r_n;
    logic        inv, inv_n;
    logic [11:0] operand12_n;
    logic        ok_n, inverted_n, carry_out_n, carry_valid_n;
    logic [4:0]  sh;
    logic [31:0] t;

    // Rotate left by 2*r; a shift by 32 yields zero, so sh=0 leaves cand unchanged.
    assign sh = {r, 1'b0};
    assign t  = (cand << sh) | (cand >> (6'd32 - {1'b0, sh}));

    always_comb begin
        state_n       = state;
        cand_n        = cand;
        r_n           = r;
        inv_n         = inv;
        operand12_n   = operand12;
        ok_n          = ok;
        inverted_n    = inverted;
        carry_out_n   = carry_out;
        carry_valid_n = carry_valid;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n       = SEARCH;
                    cand_n        = value;
                    r_n           = 4'd0;
                    inv_n         = 1'b0;
                    operand12_n   = 12'h000;
                    ok_n          = 1'b0;
                    inverted_n    = 1'b0;
                    carry_out_n   = 1'b0;
                    carry_valid_n = 1'b0;
                end
            end
            SEARCH, SEARCH_INV: begin
                if (t[31:8] == 24'd0) begin
                    state_n       = DONE;
                    operand12_n   = {r, t[7:0]};
                    ok_n          = 1'b1;
                    inverted_n    = inv;
                    carry_out_n   = cand[31];
                    carry_valid_n = (r != 4'd0);
                end else if (r != 4'd15) begin
                    r_n = r + 4'd1;
                end else if (state == SEARCH && TRY_INVERT) begin
                    // cand still holds the accepted value here, so its inverse is ~value.
                    state_n = SEARCH_INV;
                    cand_n  = ~cand;
                    r_n     = 4'd0;
                    inv_n   = 1'b1;
                end else begin
                    state_n       = DONE;
                    operand12_n   = 12'h000;
                    ok_n          = 1'b0;
                    inverted_n    = 1'b0;
                    carry_out_n   = 1'b0;
                    carry_valid_n = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cand        <= 32'd0;
            r           <= 4'd0;
            inv         <= 1'b0;
            operand12   <= 12'h000;
            ok          <= 1'b0;
            inverted    <= 1'b0;
            carry_out   <= 1'b0;
            carry_valid <= 1'b0;
        end else begin
            state       <= state_n;
            cand        <= cand_n;
            r           <= r_n;
            inv         <= inv_n;
            operand12   <= operand12_n;
            ok          <= ok_n;
            inverted    <= inverted_n;
            carry_out   <= carry_out_n;
            carry_valid <= carry_valid_n;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_arm_imm_rot_encoder.sv
// Bench for arm_imm_rot_encoder: one instance with the inverse pass, one without, both
// compared against a brute-force search over every {rot4, imm8} encoding.
module tb_arm_imm_rot_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] value;
    logic        in_valid_a, in_valid_b, out_ready_a, out_ready_b;
    logic        in_ready_a, out_valid_a, ok_a, inverted_a, carry_out_a, carry_valid_a;
    logic        in_ready_b, out_valid_b, ok_b, inverted_b, carry_out_b, carry_valid_b;
    logic [11:0] operand12_a, operand12_b;
    logic [1:0]  dbg_state_a, dbg_state_b;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    arm_imm_rot_encoder #(.TRY_INVERT(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .value(value), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .operand12(operand12_a), .ok(ok_a), .inverted(inverted_a),
        .carry_out(carry_out_a), .carry_valid(carry_valid_a), .dbg_state(dbg_state_a)
    );

    arm_imm_rot_encoder #(.TRY_INVERT(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .value(value), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .operand12(operand12_b), .ok(ok_b), .inverted(inverted_b),
        .carry_out(carry_out_b), .carry_valid(carry_valid_b), .dbg_state(dbg_state_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: enumerate every encoding in ascending rotation order and take the first
    // whose decoded constant equals value (then ~value when the inverse pass is enabled).
    function automatic void ref_encode(input logic [31:0] v, input bit try_inv,
                                       output logic [31:0] e_op, output logic [31:0] e_ok,
                                       output logic [31:0] e_inv, output logic [31:0] e_co,
                                       output logic [31:0] e_cv, output logic [31:0] e_lat);
        bit found = 0;
        logic [31:0] c;
        e_op = 0; e_ok = 0; e_inv = 0; e_co = 0; e_cv = 0;
        e_lat = try_inv ? 33 : 17;
        for (int pass = 0; pass < (try_inv ? 2 : 1); pass++) begin
            c = pass ? ~v : v;
            for (int rot = 0; rot < 16; rot++) begin
                for (int imm = 0; imm < 256; imm++) begin
                    if (!found && ror32(32'(imm), 2 * rot) == c) begin
                        found = 1;
                        e_op  = 32'(rot * 256 + imm);
                        e_ok  = 1;
                        e_inv = 32'(pass);
                        e_co  = {31'd0, c[31]};
                        e_cv  = (rot != 0) ? 1 : 0;
                        e_lat = 32'(2 + rot + 16 * pass);
                    end
                end
            end
        end
    endfunction

    // One request to both instances with out_ready high; latency is counted in edges after
    // acceptance, sampled at the falling edge that precedes each rising edge.
    task automatic run(input logic [31:0] v);
        logic [31:0] lat_a = 0, lat_b = 0;
        logic [31:0] e_op, e_ok, e_inv, e_co, e_cv, e_lat;
        logic [11:0] op_a = 0, op_b = 0;
        logic o_a = 0, i_a = 0, co_a = 0, cv_a = 0, o_b = 0, i_b = 0, co_b = 0, cv_b = 0;
        string s;
        s = $sformatf("%h", v);
        check({"in_ready_a ", s}, {31'd0, in_ready_a}, 1);
        check({"in_ready_b ", s}, {31'd0, in_ready_b}, 1);
        value = v; in_valid_a = 1; in_valid_b = 1;
        @(posedge clk); #1;
        in_valid_a = 0; in_valid_b = 0; value = $urandom;
        for (int n = 1; n <= 40 && (lat_a == 0 || lat_b == 0); n++) begin
            @(negedge clk);
            if (out_valid_a && lat_a == 0) begin
                lat_a = n; op_a = operand12_a; o_a = ok_a; i_a = inverted_a;
                co_a = carry_out_a; cv_a = carry_valid_a;
            end
            if (out_valid_b && lat_b == 0) begin
                lat_b = n; op_b = operand12_b; o_b = ok_b; i_b = inverted_b;
                co_b = carry_out_b; cv_b = carry_valid_b;
            end
        end
        ref_encode(v, 1'b1, e_op, e_ok, e_inv, e_co, e_cv, e_lat);
        check({"lat_a ", s}, lat_a, e_lat);
        check({"op_a ", s}, {20'd0, op_a}, e_op);
        check({"ok_a ", s}, {31'd0, o_a}, e_ok);
        check({"inv_a ", s}, {31'd0, i_a}, e_inv);
        check({"co_a ", s}, {31'd0, co_a}, e_co);
        check({"cv_a ", s}, {31'd0, cv_a}, e_cv);
        ref_encode(v, 1'b0, e_op, e_ok, e_inv, e_co, e_cv, e_lat);
        check({"lat_b ", s}, lat_b, e_lat);
        check({"op_b ", s}, {20'd0, op_b}, e_op);
        check({"ok_b ", s}, {31'd0, o_b}, e_ok);
        check({"inv_b ", s}, {31'd0, i_b}, e_inv);
        check({"co_b ", s}, {31'd0, co_b}, e_co);
        check({"cv_b ", s}, {31'd0, cv_b}, e_cv);
        @(posedge clk); #1;
    endtask

    task automatic stall_test();
        int n = 0;
        value = 32'hFF00_0000; in_valid_a = 1; out_ready_a = 0;
        @(posedge clk); #1;
        in_valid_a = 0;
        while (!out_valid_a && n < 40) begin
            @(negedge clk); n++;
        end
        check("stall_lat", 32'(n), 6);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid_a = 1; value = $urandom;
            @(negedge clk);
            check("stall_valid", {31'd0, out_valid_a}, 1);
            check("stall_op", {20'd0, operand12_a}, 32'h4FF);
            check("stall_co", {31'd0, carry_out_a}, 1);
            check("stall_in_ready", {31'd0, in_ready_a}, 0);
        end
        in_valid_a = 0; out_ready_a = 1;
        @(posedge clk); #1;
        check("after_stall_in_ready", {31'd0, in_ready_a}, 1);
        check("after_stall_out_valid", {31'd0, out_valid_a}, 0);
    endtask

    task automatic reset_abort_test();
        int seen = 0;
        value = 32'h0000_0102; in_valid_a = 1;
        @(posedge clk); #1;
        in_valid_a = 0;
        repeat (4) @(posedge clk);
        #1 reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
        check("abort_in_ready", {31'd0, in_ready_a}, 1);
        check("abort_out_valid", {31'd0, out_valid_a}, 0);
        check("abort_ok", {31'd0, ok_a}, 0);
        check("abort_op", {20'd0, operand12_a}, 0);
        repeat (40) begin
            @(negedge clk);
            if (out_valid_a) seen++;
        end
        check("abort_no_result", 32'(seen), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] v;
        reset_n = 0; in_valid_a = 0; in_valid_b = 0; out_ready_a = 1; out_ready_b = 1;
        value = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready_a}, 1);
        check("rst_out_valid", {31'd0, out_valid_a}, 0);
        check("rst_op", {20'd0, operand12_a}, 0);
        check("rst_flags", {28'd0, ok_a, inverted_a, carry_out_a, carry_valid_a}, 0);
        reset_n = 1;
        @(posedge clk); #1;

        run(32'h0000_00FF);
        run(32'hFF00_0000);
        run(32'hFFFF_FF00);
        run(32'h0000_0102);
        run(32'h0000_03FC);
        run(32'h0000_0000);
        run(32'hFFFF_FFFF);
        stall_test();
        reset_abort_test();

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: v = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
                1: v = ~ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
                2: v = $urandom;
                default: v = 32'($urandom_range(0, 1023));
            endcase
            run(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
